// File: rtl/fib_pkg.sv
// Shared types and defaults for the LPM forwarding table and its neighbours.
package fib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L_HASH,
    L_PROBE,
    RESP,
    U_HASH,
    U_WRITE
  } fib_state_e;

  localparam logic UPD_INSERT = 1'b1;
  localparam logic UPD_DELETE = 1'b0;

  localparam int FIB_PREFIX_W = 64;
  localparam int FIB_HASH_W   = 10;
  localparam int FIB_FACE_W   = 4;

endpackage

// File: rtl/fib_lpm_table_if.sv
// Lookup, response and update channels between the FIB and its clients.
interface fib_lpm_table_if
  import fib_pkg::*;
#(
  parameter int PREFIX_W = FIB_PREFIX_W,
  parameter int FACE_W   = FIB_FACE_W
);
  localparam int LEN_W = $clog2(PREFIX_W + 1);

  logic                lkp_valid;
  logic                lkp_ready;
  logic [PREFIX_W-1:0] lkp_prefix;
  logic [LEN_W-1:0]    lkp_len;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_hit;
  logic [LEN_W-1:0]    rsp_len;
  logic [FACE_W-1:0]   rsp_face;
  logic [PREFIX_W-1:0] rsp_prefix;

  logic                upd_valid;
  logic                upd_ready;
  logic                upd_op;
  logic [PREFIX_W-1:0] upd_prefix;
  logic [LEN_W-1:0]    upd_len;
  logic [FACE_W-1:0]   upd_face;
  logic                upd_done;
  logic                upd_err;

  modport master (
    output lkp_valid, lkp_prefix, lkp_len,
    input  lkp_ready,
    input  rsp_valid, rsp_hit, rsp_len, rsp_face, rsp_prefix,
    output rsp_ready,
    output upd_valid, upd_op, upd_prefix, upd_len, upd_face,
    input  upd_ready, upd_done, upd_err
  );

  modport slave (
    input  lkp_valid, lkp_prefix, lkp_len,
    output lkp_ready,
    output rsp_valid, rsp_hit, rsp_len, rsp_face, rsp_prefix,
    input  rsp_ready,
    input  upd_valid, upd_op, upd_prefix, upd_len, upd_face,
    output upd_ready, upd_done, upd_err
  );

endinterface

// File: rtl/fib_hash.sv
// Registered length-masked XOR-fold hash; the PIT uses the same folding.
module fib_hash #(
  parameter int PREFIX_W = 64,
  parameter int HASH_W   = 10,
  localparam int LEN_W   = $clog2(PREFIX_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PREFIX_W-1:0] prefix,
  input  logic [LEN_W-1:0]    len,
  output logic [HASH_W-1:0]   hash
);

  function automatic logic [HASH_W-1:0] fold(input logic [PREFIX_W-1:0] p,
                                             input logic [LEN_W-1:0]    l);
    logic [PREFIX_W-1:0] m;
    logic [HASH_W-1:0]   h;
    m = p & ~({PREFIX_W{1'b1}} >> l);
    h = '0;
    for (int c = 0; c < PREFIX_W; c += HASH_W)
      h ^= HASH_W'(m >> c);
    // spread the length over both halves so short prefixes do not cluster
    h ^= HASH_W'(l) ^ (HASH_W'(l) << (HASH_W / 2));
    return h;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     hash <= '0;
    else if (en) hash <= fold(prefix, len);
  end

endmodule

// File: rtl/fib_lpm_table.sv
// Longest-prefix-match FIB: per-length hashed valid/face tables probed downward.
// FIB_DEFAULT_ROUTE_EN adds default_face/default_en returned on a miss.
module fib_lpm_table
  import fib_pkg::*;
#(
  parameter int PREFIX_W = FIB_PREFIX_W,
  parameter int HASH_W   = FIB_HASH_W,
  parameter int FACE_W   = FIB_FACE_W,
  localparam int LEN_W   = $clog2(PREFIX_W + 1),
  localparam int CNT_W   = $clog2(PREFIX_W * (2 ** HASH_W) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  fib_lpm_table_if.slave    bus,
`ifdef FIB_DEFAULT_ROUTE_EN
  input  logic [FACE_W-1:0] default_face,
  input  logic              default_en,
`endif
  output logic [CNT_W-1:0]  entry_count,
  output logic              busy
);

  localparam int SLOTS = 2 ** HASH_W;
  localparam int LVL_W = $clog2(PREFIX_W);

  fib_state_e state, state_nxt;

  logic [PREFIX_W-1:0]            key_q;
  logic [LEN_W-1:0]               cur_len;
  logic [FACE_W-1:0]              face_q;
  logic                           op_q;
  logic                           err_q;
  logic                           hit_q;
  logic [LEN_W-1:0]               len_q;
  logic [FACE_W-1:0]              rface_q;
  logic [HASH_W-1:0]              hash_q;
  logic [PREFIX_W-1:0][SLOTS-1:0] valid_q;
  logic [FACE_W-1:0]              face_mem [PREFIX_W][SLOTS];

  logic [LVL_W-1:0]  lvl;
  logic              slot_vld;
  logic [LEN_W-1:0]  lkp_len_c;
  logic              upd_bad;
  logic              upd_fire;
  logic              lkp_fire;
  logic              hash_en;
  logic [FACE_W-1:0] miss_face;

`ifdef FIB_DEFAULT_ROUTE_EN
  assign miss_face = default_en ? default_face : '0;
`else
  assign miss_face = '0;
`endif

  // table row for the length being probed or written (cur_len >= 1 there)
  assign lvl       = LVL_W'(cur_len - 1'b1);
  assign slot_vld  = valid_q[lvl][hash_q];
  assign lkp_len_c = (bus.lkp_len > LEN_W'(PREFIX_W)) ? LEN_W'(PREFIX_W) : bus.lkp_len;
  assign upd_bad   = (bus.upd_len == '0) || (bus.upd_len > LEN_W'(PREFIX_W));

  fib_hash #(
    .PREFIX_W (PREFIX_W),
    .HASH_W   (HASH_W)
  ) u_hash (
    .clk    (clk),
    .rst    (rst),
    .en     (hash_en),
    .prefix (key_q),
    .len    (cur_len),
    .hash   (hash_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.lkp_ready = 1'b0;
    bus.upd_ready = 1'b0;
    upd_fire      = 1'b0;
    lkp_fire      = 1'b0;
    hash_en       = 1'b0;
    case (state)
      IDLE: begin
        bus.upd_ready = 1'b1;
        bus.lkp_ready = !bus.upd_valid;
        upd_fire      = bus.upd_valid;
        lkp_fire      = bus.lkp_valid && !bus.upd_valid;
        if (upd_fire)      state_nxt = upd_bad ? IDLE : U_HASH;
        else if (lkp_fire) state_nxt = (lkp_len_c == '0) ? RESP : L_HASH;
      end
      L_HASH: begin
        hash_en   = 1'b1;
        state_nxt = L_PROBE;
      end
      L_PROBE:  state_nxt = (slot_vld || cur_len == LEN_W'(1)) ? RESP : L_HASH;
      RESP:     if (bus.rsp_ready) state_nxt = IDLE;
      U_HASH: begin
        hash_en   = 1'b1;
        state_nxt = U_WRITE;
      end
      U_WRITE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      cur_len     <= '0;
      face_q      <= '0;
      op_q        <= 1'b0;
      err_q       <= 1'b0;
      hit_q       <= 1'b0;
      len_q       <= '0;
      rface_q     <= '0;
      valid_q     <= '0;
      entry_count <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_fire) begin
            key_q   <= bus.upd_prefix;
            cur_len <= bus.upd_len;
            face_q  <= bus.upd_face;
            op_q    <= bus.upd_op;
            err_q   <= upd_bad;
          end else if (lkp_fire) begin
            // response regs start as a miss; a hit in L_PROBE overwrites them
            key_q   <= bus.lkp_prefix;
            cur_len <= lkp_len_c;
            hit_q   <= 1'b0;
            len_q   <= '0;
            rface_q <= miss_face;
          end
        end
        L_PROBE: begin
          if (slot_vld) begin
            hit_q   <= 1'b1;
            len_q   <= cur_len;
            rface_q <= face_mem[lvl][hash_q];
          end else if (cur_len != LEN_W'(1)) begin
            cur_len <= cur_len - 1'b1;
          end
        end
        U_WRITE: begin
          if (op_q == UPD_INSERT) begin
            valid_q[lvl][hash_q] <= 1'b1;
            if (!slot_vld) entry_count <= entry_count + 1'b1;
          end else begin
            valid_q[lvl][hash_q] <= 1'b0;
            if (slot_vld) entry_count <= entry_count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == U_WRITE && op_q == UPD_INSERT)
      face_mem[lvl][hash_q] <= face_q;
  end

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_hit    = hit_q;
  assign bus.rsp_len    = len_q;
  assign bus.rsp_face   = rface_q;
  assign bus.rsp_prefix = key_q;
  assign bus.upd_done   = (state == U_WRITE) || err_q;
  assign bus.upd_err    = err_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_fib_lpm_table.sv
// Scoreboard bench for fib_lpm_table: directed updates/lookups, checked by a monitor.
module tb_fib_lpm_table;

  localparam int PW = 64;
  localparam int FW = 4;
  localparam int LW = 7;
  localparam int CW = 17;

`ifdef FIB_DEFAULT_ROUTE_EN
  localparam logic [FW-1:0] MISS_FACE = 4'd7;
  logic [FW-1:0] default_face = 4'd7;
  logic          default_en   = 1'b1;
`else
  localparam logic [FW-1:0] MISS_FACE = 4'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] entry_count;
  logic          busy;

  fib_lpm_table_if #(.PREFIX_W(PW), .FACE_W(FW)) bus ();

  fib_lpm_table #(.PREFIX_W(PW), .HASH_W(10), .FACE_W(FW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
`ifdef FIB_DEFAULT_ROUTE_EN
    .default_face (default_face),
    .default_en   (default_en),
`endif
    .entry_count  (entry_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not seen (cycle %0d)", nm, cyc);
  endtask

  typedef struct {
    logic          hit;
    logic [LW-1:0] len;
    logic [FW-1:0] face;
    logic [PW-1:0] prefix;
    int            cyc;
  } rexp_t;

  typedef struct {
    logic err;
    int   cnt;
    int   cyc;
  } uexp_t;

  rexp_t rq[$];
  uexp_t uq[$];

  // monitor: pops expectations as the DUT presents responses / completions
  rexp_t cur;
  bit    seen     = 0;
  bit    cnt_pend = 0;
  int    cnt_exp  = 0;

  always @(negedge clk) begin
    uexp_t u;
    if (rst) begin
      seen     = 0;
      cnt_pend = 0;
    end else begin
      if (cnt_pend) begin
        chk("entry_count", entry_count, cnt_exp);
        cnt_pend = 0;
      end
      if (bus.upd_done) begin
        if (uq.size() == 0) fail_now("expected_upd_done");
        else begin
          u = uq.pop_front();
          chk("upd_err", bus.upd_err, u.err);
          chk("upd_latency", cyc, u.cyc);
          cnt_pend = 1;
          cnt_exp  = u.cnt;
        end
      end
      if (bus.rsp_valid) begin
        if (!seen) begin
          if (rq.size() == 0) fail_now("expected_rsp");
          else begin
            cur = rq.pop_front();
            chk("rsp_hit", bus.rsp_hit, cur.hit);
            chk("rsp_len", bus.rsp_len, cur.len);
            chk("rsp_face", bus.rsp_face, cur.face);
            chk("rsp_prefix", bus.rsp_prefix, cur.prefix);
            chk("rsp_latency", cyc, cur.cyc);
            seen = 1;
          end
        end else begin
          chk("hold_hit", bus.rsp_hit, cur.hit);
          chk("hold_len", bus.rsp_len, cur.len);
          chk("hold_face", bus.rsp_face, cur.face);
          chk("hold_prefix", bus.rsp_prefix, cur.prefix);
        end
        if (bus.rsp_ready) seen = 0;
      end
    end
  end

  task automatic do_upd(input logic op, input logic [PW-1:0] p, input logic [LW-1:0] l,
                        input logic [FW-1:0] f, input logic err, input int cnt, input int d);
    bit ok, r;
    ok = 0;
    bus.upd_valid = 1'b1; bus.upd_op = op; bus.upd_prefix = p;
    bus.upd_len = l; bus.upd_face = f;
    for (int i = 0; i < 500 && !ok; i++) begin
      #1 r = bus.upd_ready;
      @(posedge clk);
      #1 ok = r;
    end
    bus.upd_valid = 1'b0;
    if (!ok) fail_now("upd_accept");
    else uq.push_back('{err, cnt, cyc + d - 1});
  endtask

  task automatic do_lkp(input logic [PW-1:0] p, input logic [LW-1:0] l, input logic hit,
                        input logic [LW-1:0] ml, input logic [FW-1:0] f, input int d,
                        input bit push);
    bit ok, r;
    ok = 0;
    bus.lkp_valid = 1'b1; bus.lkp_prefix = p; bus.lkp_len = l;
    for (int i = 0; i < 500 && !ok; i++) begin
      #1 r = bus.lkp_ready;
      @(posedge clk);
      #1 ok = r;
    end
    bus.lkp_valid = 1'b0;
    if (!ok) fail_now("lkp_accept");
    else if (push) rq.push_back('{hit, ml, f, p, cyc + d - 1});
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) fail_now("idle");
  endtask

  localparam logic [PW-1:0] P_AB   = 64'hAB00_0000_0000_0000;
  localparam logic [PW-1:0] P_ABCD = 64'hABCD_0000_0000_0000;
  localparam logic [PW-1:0] P_AB12 = 64'hAB12_3456_789A_BCDE;
  localparam logic [PW-1:0] P_1234 = 64'h1234_5678_0000_0000;
  localparam logic [PW-1:0] P_C0   = 64'hC000_0000_0000_0000;

  initial begin
    bus.lkp_valid = 0; bus.lkp_prefix = '0; bus.lkp_len = '0;
    bus.upd_valid = 0; bus.upd_op = 0; bus.upd_prefix = '0; bus.upd_len = '0; bus.upd_face = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_lkp_ready", bus.lkp_ready, 1);
    chk("rst_upd_ready", bus.upd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_hit", bus.rsp_hit, 0);
    chk("rst_upd_done", bus.upd_done, 0);
    chk("rst_entry_count", entry_count, 0);
    chk("rst_busy", busy, 0);

    do_upd(1'b1, P_AB, 7'd8, 4'd3, 1'b0, 1, 2);
    do_lkp(P_ABCD, 7'd16, 1'b1, 7'd8, 4'd3, 19, 1);
    do_lkp(P_AB, 7'd8, 1'b1, 7'd8, 4'd3, 3, 1);
    do_lkp(P_AB12, 7'd70, 1'b1, 7'd8, 4'd3, 115, 1);
    do_lkp(P_AB12, 7'd0, 1'b0, 7'd0, MISS_FACE, 1, 1);
    do_lkp(P_1234, 7'd4, 1'b0, 7'd0, MISS_FACE, 9, 1);

    do_upd(1'b1, P_AB, 7'd8, 4'd5, 1'b0, 1, 2);
    do_lkp(P_ABCD, 7'd8, 1'b1, 7'd8, 4'd5, 3, 1);
    do_upd(1'b0, P_AB, 7'd8, 4'd0, 1'b0, 0, 2);
    do_upd(1'b0, P_AB, 7'd8, 4'd0, 1'b0, 0, 2);
    do_lkp(P_AB, 7'd8, 1'b0, 7'd0, MISS_FACE, 17, 1);

    // same-cycle update and lookup: update goes first
    wait_idle();
    bus.upd_valid = 1'b1; bus.lkp_valid = 1'b1;
    bus.lkp_prefix = P_C0; bus.lkp_len = 7'd2;
    #1;
    chk("tie_lkp_ready", bus.lkp_ready, 0);
    chk("tie_upd_ready", bus.upd_ready, 1);
    do_upd(1'b1, P_C0, 7'd2, 4'd9, 1'b0, 1, 2);
    do_lkp(P_C0, 7'd2, 1'b1, 7'd2, 4'd9, 3, 1);

    do_upd(1'b1, P_C0, 7'd0, 4'd1, 1'b1, 1, 1);
    do_upd(1'b1, P_C0, 7'd65, 4'd1, 1'b1, 1, 1);

    // backpressure on the response channel
    wait_idle();
    bus.rsp_ready = 1'b0;
    do_lkp(P_C0, 7'd3, 1'b1, 7'd2, 4'd9, 5, 1);
    begin : hold_wait
      bit ok;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        ok = bus.rsp_valid;
      end
      if (!ok) fail_now("hold_rsp_valid");
    end
    repeat (5) @(negedge clk);
    chk("hold_rsp_valid", bus.rsp_valid, 1);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;

    // reset while probing
    wait_idle();
    do_lkp(P_AB12, 7'd64, 1'b0, 7'd0, MISS_FACE, 129, 0);
    @(posedge clk);
    #1;
    chk("probe_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_entry_count", entry_count, 0);
    chk("midrst_lkp_ready", bus.lkp_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    do_lkp(P_C0, 7'd2, 1'b0, 7'd0, MISS_FACE, 5, 1);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", rq.size(), 0);
    chk("upd_queue_drained", uq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fib_lpm_table.md
# fib_lpm_table

Parametrised longest-prefix-match FIB for the NDN router. It stores per-length hashed entries and accepts insert and delete updates from the control path. It answers PIT-side lookups by probing from the requested length downward and returns the matched length and outgoing face. It sits between the PIT and the outgoing interface arbiter.

## Interface
- PREFIX_W, 64: prefix width in bits; also the maximum prefix length.
- HASH_W, 10: hash width; each length has 2^HASH_W slots.
- FACE_W, 4: outgoing face id width.
- LEN_W, $clog2(PREFIX_W+1): length field width (derived, not overridable).
- CNT_W, $clog2(PREFIX_W*2^HASH_W+1): entry counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- lkp_valid / lkp_ready  in / out  1 / 1  lookup request handshake.
- lkp_prefix, lkp_len  in  PREFIX_W, LEN_W  lookup key; MSB-aligned.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_hit  out  1  match found.
- rsp_len  out  LEN_W  matched length; 0 on miss.
- rsp_face  out  FACE_W  face of the matched entry.
- rsp_prefix  out  PREFIX_W  echoed request prefix.
- upd_valid / upd_ready  in / out  1 / 1  update handshake.
- upd_op  in  1  1 = insert, 0 = delete.
- upd_prefix, upd_len, upd_face  in  PREFIX_W, LEN_W, FACE_W  update key and face.
- upd_done  out  1  one-cycle completion pulse.
- upd_err  out  1  qualifies upd_done; length 0 or length > PREFIX_W.
- entry_count  out  CNT_W  number of valid entries.
- busy  out  1  FSM not in IDLE.

## Operation
- Storage: valid[PREFIX_W][2^HASH_W] in flops, cleared on reset. face[PREFIX_W][2^HASH_W] has no reset.
- Key formation: prefix bits below position PREFIX_W-len are zeroed, then the masked prefix is hashed with len. Collisions alias; no tag is stored.
- FSM states: IDLE, L_HASH, L_PROBE, RESP, U_HASH, U_WRITE.
- IDLE: upd_ready=1, lkp_ready=!upd_valid; an update wins a tie with a lookup.
  - Accepted lookup: latch prefix; cur_len=min(lkp_len, PREFIX_W).
    - cur_len==0 → RESP with a miss.
    - Otherwise → L_HASH.
  - Accepted update:
    - Length 0 or length > PREFIX_W → upd_done=1, upd_err=1, stay in IDLE.
    - Otherwise → U_HASH.
- L_HASH: hash is registered; → L_PROBE.
- L_PROBE: read valid[cur_len-1][hash].
  - Hit → RESP with rsp_hit=1, rsp_len=cur_len, rsp_face from the entry.
  - Miss with cur_len==1 → RESP with a miss.
  - Otherwise decrement cur_len → L_HASH.
- RESP: rsp_valid held with stable outputs until rsp_ready; → IDLE on the handshake.
- U_HASH → U_WRITE.
  - Insert: set valid and write face. entry_count increments only if the slot was invalid; an existing slot's face is overwritten.
  - Delete: clear valid. entry_count decrements only if the slot was valid.
  - upd_done pulses in U_WRITE; → IDLE.
- Miss outputs (without default route): rsp_hit=0, rsp_len=0, rsp_face=0.

## Timing
- Reset values: all outputs 0 except lkp_ready=1 and upd_ready=1 (IDLE, upd_valid low); entry_count=0.
- Lookup latency, with acceptance edge = cycle 0:
  - Hit at length M for request length L: rsp_valid first high at cycle 1+2*(L-M+1).
  - Miss: cycle 1+2*L.
  - Request length 0: cycle 1.
- Update latency: upd_done at cycle 2; erroneous updates at cycle 1.
- Throughput: one request in flight. A new request is accepted no earlier than the cycle after the RESP handshake or upd_done.
- Reset mid-operation: FSM to IDLE, rsp_valid drops, all valid bits clear, entry_count=0.

## Configuration
- FIB_DEFAULT_ROUTE_EN defined:
  - Adds input default_face (FACE_W) and input default_en (1).
  - A miss with default_en=1 returns rsp_hit=0, rsp_len=0, rsp_face=default_face.
- Macro undefined: the ports are absent and a miss returns rsp_face=0.

## Structure
- Package fib_pkg holds:
  - FSM state enum.
  - Constants: UPD_INSERT=1, UPD_DELETE=0.
  - Default values for PREFIX_W, HASH_W and FACE_W.
- Sub-module fib_hash: masks the prefix by length, XOR-folds it to HASH_W bits mixed with the length, and registers the result (1 cycle). The same function is shared with the PIT hash.

## Test plan
- After reset, insert prefix 0xAB00…00 len 8 face 3 → upd_done at cycle 2, upd_err=0, entry_count=1.
- Lookup 0xABCD…, len 16 → rsp_valid at cycle 19 with rsp_hit=1, rsp_len=8, rsp_face=3.
- Lookup of an absent prefix at len 4 → rsp_valid at cycle 9 with rsp_hit=0, rsp_len=0. Repeat with FIB_DEFAULT_ROUTE_EN, default_en=1 and default_face=7 → rsp_face=7.
- Re-insert the same key with face 5, then delete it twice → entry_count goes 1, 1, 0, 0; a later lookup misses.
- upd_valid and lkp_valid asserted in the same cycle → update accepted first and lkp_ready=0 that cycle; the lookup is served afterwards. An insert with len 0 → upd_err=1 at cycle 1.
- Hold rsp_ready=0 for 5 cycles → outputs stable. Assert rst during L_PROBE → IDLE, rsp_valid=0, entry_count=0.
